// File: rtl/mfp_usart_tx.sv
// MFP68901 USART transmitter: UDR holding register, shift register and async framing FSM.
// Bit timing comes from one-cycle baud strobes (timer D output), optionally divided by OVERSAMPLE.
module mfp_usart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TXCLK_EN,
  input  logic       CLK16,
  input  logic [1:0] WL,
  input  logic [1:0] ST,
  input  logic       PE,
  input  logic       EO,
  input  logic       TX_EN,
  input  logic       BRK,
  input  logic       DAT_WE,
  input  logic [7:0] DAT_I,
  output logic       SO,
  output logic       BUF_EMPTY,
  output logic       EMPTY_PULSE,
  output logic       END_PULSE,
  output logic       BUSY
);

  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SUB_HALF = SW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q;
  logic          empty_q;
  logic          par_q, par_d;
  logic [1:0]    wl_q, wl_d;
  logic [1:0]    st_q, st_d;
  logic          pe_q, pe_d;
  logic          empty_pulse_q;
  logic          end_pulse_q;
  logic          end_pend_q;
  logic          tx_en_q;

  logic          bit_tick;
  logic          stop_done;
  logic          load;
  logic          so_c;
  logic [2:0]    last_bit;
  logic          tx_fall;

  assign bit_tick = TXCLK_EN & (~CLK16 | (sub_q == SUB_LAST));
  assign last_bit = 3'd7 - {1'b0, wl_q};
  assign tx_fall  = tx_en_q & ~TX_EN;

  // 1.5 stop bits in x16 mode: one full bit, then half a bit of strobes.
  always_comb begin
    stop_done = 1'b0;
    if (!st_q[1])
      stop_done = bit_tick;
    else if (st_q == 2'b10 && CLK16 && cnt_q == 3'd1)
      stop_done = TXCLK_EN & (sub_q == SUB_HALF);
    else
      stop_done = bit_tick & (cnt_q == 3'd1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    wl_d    = wl_q;
    st_d    = st_q;
    pe_d    = pe_q;
    load    = 1'b0;
    so_c    = 1'b1;
    case (state_q)
      S_IDLE: begin
        so_c = 1'b1;
        if (TXCLK_EN && TX_EN) begin
          if (BRK)
            state_d = S_BREAK;
          else if (!empty_q)
            load = 1'b1;
        end
      end
      S_START: begin
        so_c = 1'b0;
        if (bit_tick) begin
          state_d = S_DATA;
          cnt_d   = 3'd0;
        end
      end
      S_DATA: begin
        so_c = shift_q[0];
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (cnt_q == last_bit) begin
            state_d = pe_q ? S_PARITY : S_STOP;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        so_c = par_q;
        if (bit_tick) begin
          state_d = S_STOP;
          cnt_d   = 3'd0;
        end
      end
      S_STOP: begin
        so_c = 1'b1;
        if (stop_done) begin
          if (TX_EN && BRK)
            state_d = S_BREAK;
          else if (TX_EN && !empty_q)
            load = 1'b1;
          else
            state_d = S_IDLE;
        end else if (bit_tick) begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_BREAK: begin
        so_c = 1'b0;
        if (bit_tick && !(TX_EN && BRK))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame format is captured here so UCR writes mid-frame only affect the next frame.
    if (load) begin
      state_d = S_START;
      shift_d = hold_q;
      cnt_d   = 3'd0;
      wl_d    = WL;
      st_d    = ST;
      pe_d    = PE;
      par_d   = (^(hold_q & (8'hFF >> WL))) ^ ~EO;
    end
  end

  always_comb begin
    sub_d = sub_q;
    if (state_q == S_IDLE || state_d == S_IDLE || !CLK16)
      sub_d = '0;
    else if (TXCLK_EN)
      sub_d = (sub_q == SUB_LAST || (state_q == S_STOP && stop_done)) ? '0 : sub_q + SW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      sub_q   <= '0;
      cnt_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      wl_q    <= 2'b00;
      st_q    <= 2'b00;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      wl_q    <= wl_d;
      st_q    <= st_d;
      pe_q    <= pe_d;
    end
  end

  // A write landing on the transfer cycle refills the buffer, so no empty event.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q        <= 8'd0;
      empty_q       <= 1'b1;
      empty_pulse_q <= 1'b0;
    end else begin
      if (DAT_WE)
        hold_q <= DAT_I;
      if (DAT_WE)
        empty_q <= 1'b0;
      else if (load)
        empty_q <= 1'b1;
      empty_pulse_q <= load & ~DAT_WE;
    end
  end

  // TX_EN falling is remembered until the FSM reaches IDLE, then reported once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_en_q     <= 1'b0;
      end_pend_q  <= 1'b0;
      end_pulse_q <= 1'b0;
    end else begin
      tx_en_q <= TX_EN;
      if (TX_EN) begin
        end_pend_q  <= 1'b0;
        end_pulse_q <= 1'b0;
      end else if ((tx_fall || end_pend_q) && state_q == S_IDLE) begin
        end_pend_q  <= 1'b0;
        end_pulse_q <= 1'b1;
      end else begin
        end_pulse_q <= 1'b0;
        if (tx_fall)
          end_pend_q <= 1'b1;
      end
    end
  end

  assign SO          = so_c;
  assign BUF_EMPTY   = empty_q;
  assign EMPTY_PULSE = empty_pulse_q;
  assign END_PULSE   = end_pulse_q;
  assign BUSY        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mfp_usart_tx.sv
// Scoreboard bench for mfp_usart_tx: expected SO levels per baud strobe are queued by the
// stimulus; a monitor pops one entry after every strobe while the transmitter is busy.
module tb_mfp_usart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TXCLK_EN;
  logic       CLK16;
  logic [1:0] WL;
  logic [1:0] ST;
  logic       PE;
  logic       EO;
  logic       TX_EN;
  logic       BRK;
  logic       DAT_WE;
  logic [7:0] DAT_I;
  logic       SO;
  logic       BUF_EMPTY;
  logic       EMPTY_PULSE;
  logic       END_PULSE;
  logic       BUSY;

  always #5 CLK = ~CLK;

  mfp_usart_tx #(.OVERSAMPLE(16)) dut (
    .CLK(CLK), .RST(RST), .TXCLK_EN(TXCLK_EN), .CLK16(CLK16), .WL(WL), .ST(ST),
    .PE(PE), .EO(EO), .TX_EN(TX_EN), .BRK(BRK), .DAT_WE(DAT_WE), .DAT_I(DAT_I),
    .SO(SO), .BUF_EMPTY(BUF_EMPTY), .EMPTY_PULSE(EMPTY_PULSE), .END_PULSE(END_PULSE),
    .BUSY(BUSY)
  );

  logic exp_q[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_pop   = 0;
  int   n_empty = 0;
  bit   mon_en  = 1'b0;
  logic strb_q  = 1'b0;
  logic mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Baud strobe: one CLK high out of every four.
  initial begin
    int div;
    div = 0;
    TXCLK_EN = 1'b0;
    forever begin
      @(negedge CLK);
      TXCLK_EN = (div == 3);
      div = (div + 1) % 4;
    end
  end

  always @(posedge CLK) strb_q <= TXCLK_EN;

  always @(negedge CLK) begin
    if (mon_en && !RST && strb_q && BUSY) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL so_unexpected: got bit %0b with no bit expected at t=%0t", SO, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("so_bit", {31'd0, SO}, {31'd0, mon_e});
        n_pop++;
      end
    end
    if (EMPTY_PULSE) n_empty++;
  end

  task automatic push_str(input string s, input int rep);
    for (int i = 0; i < s.len(); i++)
      repeat (rep) exp_q.push_back(s.getc(i) == "1");
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge CLK);
    DAT_WE = 1'b1;
    DAT_I  = d;
    @(negedge CLK);
    DAT_WE = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || BUSY) && c < maxc) begin
      @(negedge CLK);
      c++;
    end
    chk(nm, {31'd0, (exp_q.size() == 0 && !BUSY)}, 32'd1);
  endtask

  task automatic wait_pop(input string nm, input int target, input int maxc);
    int c;
    c = 0;
    while (n_pop < target && c < maxc) begin
      @(negedge CLK);
      c++;
    end
    chk(nm, {31'd0, (n_pop >= target)}, 32'd1);
  endtask

  task automatic wait_buf_empty(input string nm, input int maxc);
    int c;
    c = 0;
    while (!BUF_EMPTY && c < maxc) begin
      @(negedge CLK);
      c++;
    end
    chk(nm, {31'd0, BUF_EMPTY}, 32'd1);
  endtask

  initial begin
    int p0;
    RST = 1'b1; CLK16 = 1'b0; WL = 2'b00; ST = 2'b00; PE = 1'b0; EO = 1'b0;
    TX_EN = 1'b0; BRK = 1'b0; DAT_WE = 1'b0; DAT_I = 8'h00;
    #2;
    chk("rst_so", {31'd0, SO}, 32'd1);
    chk("rst_buf_empty", {31'd0, BUF_EMPTY}, 32'd1);
    chk("rst_empty_pulse", {31'd0, EMPTY_PULSE}, 32'd0);
    chk("rst_end_pulse", {31'd0, END_PULSE}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    mon_en = 1'b1;

    // 8N1, one strobe per bit, 0xA5
    TX_EN = 1'b1;
    n_empty = 0;
    push_str("0101001011", 1);
    wr(8'hA5);
    wait_done("t1_done", 400);
    chk("t1_so_idle", {31'd0, SO}, 32'd1);
    chk("t1_empty_pulses", n_empty, 32'd1);
    chk("t1_buf_empty", {31'd0, BUF_EMPTY}, 32'd1);

    // x16, 7 data bits, even parity, 2 stop, 0x41
    CLK16 = 1'b1; WL = 2'b01; PE = 1'b1; EO = 1'b1; ST = 2'b11;
    n_empty = 0;
    push_str("01000001011", 16);
    wr(8'h41);
    wait_done("t2_done", 1500);
    chk("t2_so_idle", {31'd0, SO}, 32'd1);
    chk("t2_empty_pulses", n_empty, 32'd1);

    // back-to-back frames, no idle gap between them
    CLK16 = 1'b0; WL = 2'b00; PE = 1'b0; ST = 2'b00;
    n_empty = 0;
    push_str("01010101010010101011", 1);
    wr(8'h55);
    wait_buf_empty("t3_xfer", 100);
    wr(8'hAA);
    wait_done("t3_done", 400);
    chk("t3_empty_pulses", n_empty, 32'd2);
    chk("t3_buf_empty", {31'd0, BUF_EMPTY}, 32'd1);

    // x16, 1.5 stop bits: 24 strobes of stop
    CLK16 = 1'b1; ST = 2'b10;
    n_empty = 0;
    push_str("000000000", 16);
    push_str("1", 24);
    wr(8'h00);
    wait_done("t4_done", 1500);
    chk("t4_so_idle", {31'd0, SO}, 32'd1);
    chk("t4_busy", {31'd0, BUSY}, 32'd0);

    // TX_EN cleared during data bit 3 with a second byte pending
    CLK16 = 1'b0; ST = 2'b00;
    n_empty = 0;
    p0 = n_pop;
    push_str("0001111001", 1);
    wr(8'h3C);
    wait_buf_empty("t5_xfer", 100);
    wr(8'h99);
    wait_pop("t5_reach_bit3", p0 + 5, 200);
    TX_EN = 1'b0;
    wait_done("t5_done", 400);
    chk("t5_end_pulse_early", {31'd0, END_PULSE}, 32'd0);
    @(negedge CLK);
    chk("t5_end_pulse", {31'd0, END_PULSE}, 32'd1);
    chk("t5_so", {31'd0, SO}, 32'd1);
    @(negedge CLK);
    chk("t5_end_pulse_clr", {31'd0, END_PULSE}, 32'd0);
    repeat (40) @(negedge CLK);
    chk("t5_no_frame", {31'd0, BUSY}, 32'd0);
    chk("t5_pending_kept", {31'd0, BUF_EMPTY}, 32'd0);
    chk("t5_empty_pulses", n_empty, 32'd1);

    // async reset in the middle of a data bit
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    TX_EN = 1'b1;
    p0 = n_pop;
    push_str("0000011111", 1);
    wr(8'hF0);
    wait_pop("t6_reach_data", p0 + 3, 200);
    chk("t6_busy_pre", {31'd0, BUSY}, 32'd1);
    chk("t6_so_pre", {31'd0, SO}, 32'd0);
    mon_en = 1'b0;
    exp_q.delete();
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_so", {31'd0, SO}, 32'd1);
    chk("t6_rst_buf_empty", {31'd0, BUF_EMPTY}, 32'd1);
    chk("t6_rst_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // break: held low while TX_EN & BRK, released on the next bit tick
    BRK = 1'b1;
    repeat (12) @(negedge CLK);
    chk("brk_busy", {31'd0, BUSY}, 32'd1);
    chk("brk_so", {31'd0, SO}, 32'd0);
    repeat (20) @(negedge CLK);
    chk("brk_so_held", {31'd0, SO}, 32'd0);
    BRK = 1'b0;
    repeat (12) @(negedge CLK);
    chk("brk_exit_so", {31'd0, SO}, 32'd1);
    chk("brk_exit_busy", {31'd0, BUSY}, 32'd0);

    // TX_EN falling while idle
    TX_EN = 1'b0;
    @(negedge CLK);
    chk("idle_end_pulse", {31'd0, END_PULSE}, 32'd1);
    @(negedge CLK);
    chk("idle_end_pulse_clr", {31'd0, END_PULSE}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
